// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard sequencer: controller states and
// EX operand forward-select encodings.
package hazard_pkg;

    typedef enum logic [1:0] {
        RST_FLUSH,
        RUN,
        MEM_WAIT,
        FAULT
    } hz_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// EX operand forward select for one source register; Memory-stage result
// takes priority over Writeback, and x0 is never forwarded.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output logic [1:0] forward_o
);

    always_comb begin
        forward_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
            forward_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
            forward_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush/forward controller for the 5-stage pipeline, including the
// post-reset flush window, variable-latency dmem waits and the dmem timeout fault.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int unsigned RESET_FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT        = 64,
    parameter int unsigned PERF_W             = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        Rs1E,
    input  logic [4:0]        Rs2E,
    input  logic [4:0]        RdE,
    input  logic              MemReadE,
    input  logic              PCSrcE,
    input  logic [4:0]        RdM,
    input  logic              RegWriteM,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic              dmem_ready,
    input  logic [4:0]        RdW,
    input  logic              RegWriteW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              StallW,
    output logic              FlushD,
    output logic              FlushE,
    output logic              mem_fault,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [3:0] FLUSH_LAST   = 4'(RESET_FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    hz_state_e         state_q;
    logic [3:0]        flush_cnt_q;
    logic [7:0]        wait_cnt_q;
    logic              mem_fault_q;
    logic [PERF_W-1:0] stall_cnt_q;

    logic mem_stall;
    logic load_use;

    forward_unit u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .forward_o     (ForwardAE)
    );

    forward_unit u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .forward_o     (ForwardBE)
    );

    // A same-cycle ready completes the access without any stall.
    assign mem_stall = (MemReadM | MemWriteM) & ~dmem_ready;
    assign load_use  = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        unique case (state_q)
            RST_FLUSH: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
            end
            FAULT: begin
                {StallF, StallD, StallE, StallM, StallW} = 5'b11111;
            end
            RUN, MEM_WAIT: begin
                // W is held, not bubbled: rewriting the regfile is harmless.
                if (mem_stall) begin
                    {StallF, StallD, StallE, StallM, StallW} = 5'b11111;
                end else if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (load_use) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RST_FLUSH;
            flush_cnt_q <= 4'd0;
            wait_cnt_q  <= 8'd0;
            mem_fault_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (StallF && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            unique case (state_q)
                RST_FLUSH: begin
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_q <= RUN;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 4'd1;
                    end
                end
                RUN: begin
                    if (mem_stall) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    // wait_cnt_q counts stalled cycles already spent on this access.
                    if (!mem_stall) begin
                        state_q <= RUN;
                    end else if (wait_cnt_q == TIMEOUT_LAST) begin
                        state_q     <= FAULT;
                        mem_fault_q <= 1'b1;
                        wait_cnt_q  <= wait_cnt_q + 8'd1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                FAULT: ;
                default: state_q <= RST_FLUSH;
            endcase
        end
    end

    assign mem_fault    = mem_fault_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed scenarios then random traffic,
// expected outputs come from a cycle-history reference model.
module tb_hazard_sequencer;

    localparam int unsigned RFC = 2;
    localparam int unsigned TMO = 4;
    localparam int unsigned PW  = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          MemReadE, PCSrcE, RegWriteM, MemReadM, MemWriteM, dmem_ready, RegWriteW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, mem_fault;
    logic [PW-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_sequencer #(
        .RESET_FLUSH_CYCLES (RFC),
        .MEM_TIMEOUT        (TMO),
        .PERF_W             (PW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Rs1D         (Rs1D),
        .Rs2D         (Rs2D),
        .Rs1E         (Rs1E),
        .Rs2E         (Rs2E),
        .RdE          (RdE),
        .MemReadE     (MemReadE),
        .PCSrcE       (PCSrcE),
        .RdM          (RdM),
        .RegWriteM    (RegWriteM),
        .MemReadM     (MemReadM),
        .MemWriteM    (MemWriteM),
        .dmem_ready   (dmem_ready),
        .RdW          (RdW),
        .RegWriteW    (RegWriteW),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .StallW       (StallW),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .mem_fault    (mem_fault),
        .stall_cycles (stall_cycles)
    );

    typedef struct {
        bit       rst;
        bit [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        bit       mre, pcs, rwm, mrm, mwm, rdy, rww;
    } in_t;

    typedef struct {
        logic [1:0]    fa, fb;
        logic [4:0]    st;  // {F, D, E, M, W}
        logic          fd, fe, flt;
        logic [PW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: cycles since reset release, stalled cycles of the current
    // dmem access, sticky fault, saturating StallF count.
    int m_age   = 0;
    int m_wait  = 0;
    bit m_fault = 1'b0;
    int m_cnt   = 0;

    function automatic logic [1:0] fwd(input bit [4:0] rs, input bit [4:0] rdm, input bit rwm,
                                       input bit [4:0] rdw, input bit rww);
        if (rwm && rdm != 0 && rdm == rs) return 2'b10;
        if (rww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic in_t idle();
        in_t v;
        v = '{default: 0};
        return v;
    endfunction

    task automatic issue(input in_t v);
        exp_t e;
        bit   mstall;
        @(posedge clk);
        #1;
        reset = v.rst;
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
        RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
        MemReadE = v.mre; PCSrcE = v.pcs; RegWriteM = v.rwm; MemReadM = v.mrm;
        MemWriteM = v.mwm; dmem_ready = v.rdy; RegWriteW = v.rww;

        e.fa  = fwd(v.rs1e, v.rdm, v.rwm, v.rdw, v.rww);
        e.fb  = fwd(v.rs2e, v.rdm, v.rwm, v.rdw, v.rww);
        e.st  = 5'b00000;
        e.fd  = 1'b0;
        e.fe  = 1'b0;
        mstall = (v.mrm || v.mwm) && !v.rdy;
        if (v.rst) begin
            m_age = 0; m_wait = 0; m_fault = 1'b0; m_cnt = 0;
        end
        e.flt = m_fault;
        e.cnt = PW'(m_cnt);
        if (v.rst || m_age < int'(RFC)) begin
            e.st = 5'b10000; e.fd = 1'b1; e.fe = 1'b1;
            m_wait = 0;
        end else if (m_fault) begin
            e.st = 5'b11111;
        end else if (mstall) begin
            e.st = 5'b11111;
            m_wait++;
            if (m_wait >= int'(TMO)) m_fault = 1'b1;
        end else begin
            m_wait = 0;
            if (v.pcs) begin
                e.fd = 1'b1; e.fe = 1'b1;
            end else if (v.mre && v.rde != 0 && (v.rde == v.rs1d || v.rde == v.rs2d)) begin
                e.st = 5'b11000; e.fe = 1'b1;
            end
        end
        sb_q.push_back(e);
        if (!v.rst) begin
            if (e.st[4] && m_cnt < (1 << PW) - 1) m_cnt++;
            if (m_age < int'(RFC)) m_age++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ForwardAE", 32'(ForwardAE), 32'(e.fa));
                chk("ForwardBE", 32'(ForwardBE), 32'(e.fb));
                chk("StallF", 32'(StallF), 32'(e.st[4]));
                chk("StallD", 32'(StallD), 32'(e.st[3]));
                chk("StallE", 32'(StallE), 32'(e.st[2]));
                chk("StallM", 32'(StallM), 32'(e.st[1]));
                chk("StallW", 32'(StallW), 32'(e.st[0]));
                chk("FlushD", 32'(FlushD), 32'(e.fd));
                chk("FlushE", 32'(FlushE), 32'(e.fe));
                chk("mem_fault", 32'(mem_fault), 32'(e.flt));
                chk("stall_cycles", 32'(stall_cycles), 32'(e.cnt));
            end
        end
    end

    initial begin : driver
        in_t v;
        reset = 1'b1;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        MemReadE = 0; PCSrcE = 0; RegWriteM = 0; MemReadM = 0; MemWriteM = 0;
        dmem_ready = 0; RegWriteW = 0;

        // Reset, then the post-reset flush window and first RUN cycle.
        v = idle(); v.rst = 1'b1;
        repeat (3) issue(v);
        v = idle();
        repeat (3) issue(v);

        // Forwarding priority and x0 handling.
        v = idle(); v.rdm = 5; v.rwm = 1; v.rdw = 5; v.rww = 1; v.rs1e = 5;
        issue(v);
        v.rdm = 0;
        issue(v);
        v.rs2e = 0; v.rdw = 0;
        issue(v);

        // Load-use, then the same with a taken branch.
        v = idle(); v.mre = 1; v.rde = 7; v.rs2d = 7;
        issue(v);
        v.pcs = 1;
        issue(v);

        // Three-cycle dmem wait then completion.
        v = idle(); v.mrm = 1;
        repeat (3) issue(v);
        v.rdy = 1;
        issue(v);
        issue(idle());

        // Branch pending during a dmem wait.
        v = idle(); v.mrm = 1; v.pcs = 1;
        repeat (2) issue(v);
        v.rdy = 1;
        issue(v);

        // Timeout into FAULT, held long enough to saturate the counter, then reset.
        v = idle(); v.mwm = 1;
        repeat (70) issue(v);
        v.rdy = 1;
        repeat (3) issue(v);
        v = idle(); v.rst = 1'b1;
        issue(v);
        v = idle();
        repeat (3) issue(v);

        // Random traffic with occasional mid-operation resets.
        for (int i = 0; i < 3000; i++) begin
            v = idle();
            v.rst  = ($urandom_range(0, 99) < 2);
            v.rs1d = 5'($urandom_range(0, 3)); v.rs2d = 5'($urandom_range(0, 3));
            v.rs1e = 5'($urandom_range(0, 3)); v.rs2e = 5'($urandom_range(0, 3));
            v.rde  = 5'($urandom_range(0, 3)); v.rdm  = 5'($urandom_range(0, 3));
            v.rdw  = 5'($urandom_range(0, 3));
            v.mre  = ($urandom_range(0, 99) < 40);
            v.pcs  = ($urandom_range(0, 99) < 15);
            v.rwm  = ($urandom_range(0, 99) < 60);
            v.rww  = ($urandom_range(0, 99) < 60);
            v.mrm  = ($urandom_range(0, 99) < 25);
            v.mwm  = ($urandom_range(0, 99) < 20);
            v.rdy  = ($urandom_range(0, 99) < 55);
            issue(v);
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        if (total == 0) begin
            bad++;
            $display("FAIL coverage: got 0 comparisons expected nonzero");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
